// File: rtl/add_order_mpid_encoder.sv
// add_order_mpid_encoder: serializes one Add Order with MPID field set into a
// gapless little-endian 64-bit word stream, carrying a sub-word residual
// between messages. Optional build macro: ADD_ORDER_MPID_TYPE_BYTE_EN
// prepends the 0x46 ('F') message-type byte to every message.
module add_order_mpid_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] timeStamp,
    input  logic [63:0] orderID,
    input  logic [31:0] orderBookID,
    input  logic [7:0]  side,
    input  logic [31:0] orderBookPosition,
    input  logic [63:0] quantity,
    input  logic [31:0] price,
    input  logic [15:0] orderAttributes,
    input  logic [7:0]  lotType,
    input  logic [55:0] participantID,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  out_bytes,
    output logic        msg_done,
    output logic [5:0]  trackerOut
);

`ifdef ADD_ORDER_MPID_TYPE_BYTE_EN
    localparam int MSG_BITS = 352;
`else
    localparam int MSG_BITS = 344;
`endif
    // Room for one message on top of the largest possible residual (56 bits).
    localparam int BUF_BITS = MSG_BITS + 56;

    typedef enum logic [1:0] {IDLE, EMIT, FLUSH} state_t;

    state_t               state, stateNext;
    logic [BUF_BITS-1:0]  buffer;
    logic [8:0]           total;
    logic [5:0]           rcnt;
    logic                 msgDone;
    logic [MSG_BITS-1:0]  msgBits;
    logic [BUF_BITS-1:0]  placed;
    logic [8:0]           totalAfter;

    // Message image, LSB first in wire order.
`ifdef ADD_ORDER_MPID_TYPE_BYTE_EN
    assign msgBits = {participantID, lotType, orderAttributes, price, quantity,
                      orderBookPosition, side, orderBookID, orderID, timeStamp, 8'h46};
`else
    assign msgBits = {participantID, lotType, orderAttributes, price, quantity,
                      orderBookPosition, side, orderBookID, orderID, timeStamp};
`endif

    // New message lands directly above the residual; bits above rcnt are always zero.
    assign placed     = BUF_BITS'(msgBits) << rcnt;
    assign totalAfter = total - 9'd64;
    assign msg_done   = msgDone;
    assign trackerOut = rcnt;

    // Next-state and handshake/output decode.
    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 64'd0;
        out_bytes = 4'd0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    stateNext = EMIT;
                else if (flush && rcnt != 6'd0)
                    stateNext = FLUSH;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = buffer[63:0];
                out_bytes = 4'd8;
                if (out_ready && totalAfter < 9'd64)
                    stateNext = IDLE;
            end
            FLUSH: begin
                out_valid = 1'b1;
                out_data  = buffer[63:0];
                out_bytes = {1'b0, rcnt[5:3]};
                if (out_ready)
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // Buffer, bit accounting and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer  <= '0;
            total   <= 9'd0;
            rcnt    <= 6'd0;
            msgDone <= 1'b0;
        end else begin
            msgDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        buffer <= buffer | placed;
                        total  <= {3'd0, rcnt} + 9'(MSG_BITS);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        buffer <= buffer >> 64;
                        total  <= totalAfter;
                        if (totalAfter < 9'd64) begin
                            rcnt    <= totalAfter[5:0];
                            msgDone <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (out_ready) begin
                        buffer <= '0;
                        rcnt   <= 6'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_order_mpid_encoder.sv
// Self-checking bench for add_order_mpid_encoder: table of messages with
// expected word counts / residuals, byte-queue reference model feeding a
// scoreboard of expected output words, plus directed flush and reset cases.
module tb_add_order_mpid_encoder;

    typedef struct {
        logic [31:0] ts;
        logic [63:0] oid;
        logic [31:0] obid;
        logic [7:0]  sd;
        logic [31:0] obp;
        logic [63:0] qty;
        logic [31:0] prc;
        logic [15:0] attr;
        logic [7:0]  lot;
        logic [55:0] pid;
        int          expWords;
        int          expTrk;
    } rec_t;

    typedef struct {
        logic [63:0] d;
        logic [3:0]  b;
    } exp_t;

`ifdef ADD_ORDER_MPID_TYPE_BYTE_EN
    localparam logic [63:0] W0A  = 64'h0607081122334446;
    localparam logic [63:0] FLW  = 64'h00000000AABBCCDD;
    localparam logic [3:0]  FLB  = 4'd4;
    localparam int          TRKA = 32;
`else
    localparam logic [63:0] W0A  = 64'h0506070811223344;
    localparam logic [63:0] FLW  = 64'h0000000000AABBCC;
    localparam logic [3:0]  FLB  = 4'd3;
    localparam int          TRKA = 24;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] timeStamp = '0;
    logic [63:0] orderID = '0;
    logic [31:0] orderBookID = '0;
    logic [7:0]  side = '0;
    logic [31:0] orderBookPosition = '0;
    logic [63:0] quantity = '0;
    logic [31:0] price = '0;
    logic [15:0] orderAttributes = '0;
    logic [7:0]  lotType = '0;
    logic [55:0] participantID = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [3:0]  out_bytes;
    logic        msg_done;
    logic [5:0]  trackerOut;

    int          nVec = 0;
    int          nErr = 0;
    int          readyMode = 0;   // 0: always ready, 1: random, 2: driven by test
    int          wordsSeen = 0;
    bit          stalled = 0;
    logic [63:0] heldD;
    logic [3:0]  heldB;
    logic [7:0]  modelB[$];
    exp_t        expQ[$];
    rec_t        tbl[8];
    rec_t        msgA;
    int          expW[8];
    int          expT[8];

    add_order_mpid_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .timeStamp(timeStamp), .orderID(orderID), .orderBookID(orderBookID),
        .side(side), .orderBookPosition(orderBookPosition), .quantity(quantity),
        .price(price), .orderAttributes(orderAttributes), .lotType(lotType),
        .participantID(participantID), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_bytes(out_bytes),
        .msg_done(msg_done), .trackerOut(trackerOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic addField(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) modelB.push_back(v[8*i +: 8]);
    endtask

    // Reference: append message bytes in wire order, drain whole words.
    task automatic modelPush(input rec_t r);
        exp_t e;
`ifdef ADD_ORDER_MPID_TYPE_BYTE_EN
        modelB.push_back(8'h46);
`endif
        addField(64'(r.ts), 4);   addField(r.oid, 8);        addField(64'(r.obid), 4);
        addField(64'(r.sd), 1);   addField(64'(r.obp), 4);   addField(r.qty, 8);
        addField(64'(r.prc), 4);  addField(64'(r.attr), 2);  addField(64'(r.lot), 1);
        addField(64'(r.pid), 7);
        while (modelB.size() >= 8) begin
            e.d = '0;
            for (int i = 0; i < 8; i++) e.d[8*i +: 8] = modelB.pop_front();
            e.b = 4'd8;
            expQ.push_back(e);
        end
    endtask

    task automatic modelFlush();
        exp_t e;
        e.d = '0;
        e.b = 4'(modelB.size());
        for (int i = 0; modelB.size() > 0; i++) e.d[8*i +: 8] = modelB.pop_front();
        expQ.push_back(e);
    endtask

    task automatic driveFields(input rec_t r);
        timeStamp = r.ts; orderID = r.oid; orderBookID = r.obid; side = r.sd;
        orderBookPosition = r.obp; quantity = r.qty; price = r.prc;
        orderAttributes = r.attr; lotType = r.lot; participantID = r.pid;
    endtask

    task automatic waitReady(input string nm, input int budget);
        int cyc = 0;
        while (!in_ready && cyc < budget) begin @(negedge clk); cyc++; end
        chk({nm, "_timeout"}, 64'(in_ready), 64'd1);
    endtask

    // Send one message, optionally check first-word latency/value, then
    // check completion pulse, residual and word count.
    task automatic sendMsg(input rec_t r, input bit chkW0, input string nm);
        @(negedge clk);
        waitReady({nm, "_accept"}, 200);
        driveFields(r);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        modelPush(r);
        wordsSeen = 0;
        @(negedge clk);
        if (chkW0) begin
            chk({nm, "_w0_valid"}, 64'(out_valid), 64'd1);
            chk({nm, "_w0"}, out_data, W0A);
        end
        waitReady({nm, "_done"}, 500);
        chk({nm, "_msg_done"}, 64'(msg_done), 64'd1);
        chk({nm, "_tracker"}, 64'(trackerOut), 64'(r.expTrk));
        chk({nm, "_words"}, 64'(wordsSeen), 64'(r.expWords));
    endtask

    task automatic doFlush(input bit expectWord, input string nm);
        int cyc = 0;
        @(negedge clk);
        flush = 1'b1;
        if (expectWord) modelFlush();
        @(posedge clk);
        #1 flush = 1'b0;
        if (expectWord) begin
            @(negedge clk);
            chk({nm, "_data"}, out_data, FLW);
            chk({nm, "_bytes"}, 64'(out_bytes), 64'(FLB));
            while (out_valid && cyc < 100) begin @(negedge clk); cyc++; end
            chk({nm, "_end"}, 64'(out_valid), 64'd0);
        end else begin
            repeat (3) begin
                @(negedge clk);
                chk({nm, "_idle"}, 64'(out_valid), 64'd0);
            end
        end
        chk({nm, "_tracker"}, 64'(trackerOut), 64'd0);
    endtask

    // Output monitor: ready generation, scoreboard compare, stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (readyMode == 0) out_ready = 1'b1;
        else if (readyMode == 1) out_ready = 1'($urandom_range(0, 1));
        if (stalled && out_valid) begin
            chk("stall_data", out_data, heldD);
            chk("stall_bytes", 64'(out_bytes), 64'(heldB));
        end
        if (out_valid) chk("in_ready_busy", 64'(in_ready), 64'd0);
        stalled = 1'b0;
        if (out_valid && !out_ready) begin
            stalled = 1'b1;
            heldD = out_data;
            heldB = out_bytes;
        end
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                nVec++; nErr++;
                $display("FAIL extra_word: got %h expected none", out_data);
            end else begin
                e = expQ.pop_front();
                chk("word_data", out_data, e.d);
                chk("word_bytes", 64'(out_bytes), 64'(e.b));
            end
            if (out_bytes == 4'd8) wordsSeen++;
        end
    end

    initial begin
`ifdef ADD_ORDER_MPID_TYPE_BYTE_EN
        expW = '{5, 6, 5, 6, 5, 6, 5, 6};
        expT = '{32, 0, 32, 0, 32, 0, 32, 0};
`else
        expW = '{5, 5, 6, 5, 5, 6, 5, 6};
        expT = '{24, 48, 8, 32, 56, 16, 40, 0};
`endif
        msgA = '{ts: 32'h11223344, oid: 64'h0102030405060708, obid: 32'hA1A2A3A4,
                 sd: 8'h42, obp: 32'hB1B2B3B4, qty: 64'hC1C2C3C4C5C6C7C8,
                 prc: 32'hD1D2D3D4, attr: 16'hE1E2, lot: 8'hF1,
                 pid: 56'hAABBCCDDEEFF00, expWords: expW[0], expTrk: TRKA};
        for (int i = 0; i < 8; i++) begin
            tbl[i].ts   = $urandom;
            tbl[i].oid  = {$urandom, $urandom};
            tbl[i].obid = $urandom;
            tbl[i].sd   = 8'($urandom);
            tbl[i].obp  = $urandom;
            tbl[i].qty  = {$urandom, $urandom};
            tbl[i].prc  = $urandom;
            tbl[i].attr = 16'($urandom);
            tbl[i].lot  = 8'($urandom);
            tbl[i].pid  = 56'({$urandom, $urandom});
            tbl[i].expWords = expW[i];
            tbl[i].expTrk   = expT[i];
        end

        // Reset state, held and released.
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_bytes", 64'(out_bytes), 64'd0);
        chk("rst_msg_done", 64'(msg_done), 64'd0);
        chk("rst_tracker", 64'(trackerOut), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Single message, first-word latency/value, then flush of residual.
        sendMsg(msgA, 1'b1, "msgA");
        doFlush(1'b1, "flushA");

        // Back-to-back table; second half with random backpressure.
        for (int i = 0; i < 8; i++) begin
            readyMode = (i < 3) ? 0 : 1;
            sendMsg(tbl[i], 1'b0, $sformatf("tbl%0d", i));
        end
        readyMode = 0;

        // Flush with nothing pending is a no-op.
        doFlush(1'b0, "flushEmpty");

        // Asynchronous reset mid-message after two words.
        readyMode = 2;
        out_ready = 1'b1;
        @(negedge clk);
        waitReady("rstMid_accept", 200);
        driveFields(tbl[0]);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        modelPush(tbl[0]);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstMid_out_valid", 64'(out_valid), 64'd0);
        chk("rstMid_tracker", 64'(trackerOut), 64'd0);
        chk("rstMid_in_ready", 64'(in_ready), 64'd1);
        expQ.delete();
        modelB.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        readyMode = 0;
        sendMsg(msgA, 1'b1, "afterRst");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
